// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq : 24-bit execute-stage ALU with a sequential multiplier.
//
// Logic, add/sub, compare and shift ops return a registered result one cycle
// after acceptance.  MUL is computed by an iterative shift-add engine (one
// step per cycle, WIDTH steps), during which the block holds i_in_ready low.
//
// Optional build macro: ALU_OVF_EN -- adds o_ovf, signed overflow for ADD/SUB.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operation request
//   o_in_ready   block can accept a request this cycle
//   i_alu_ctrl   4-bit operation code from the ALU control decoder
//   i_a, i_b     operands
//   o_out_valid  one-cycle pulse, result/zero/eq/illegal valid
//   o_result     registered result
//   o_zero       result == 0
//   o_eq         a == b of the accepted request (used for BNE)
//   o_ovf        signed overflow of ADD/SUB (ALU_OVF_EN only)
//   o_illegal    accepted code not in the code table
// ---------------------------------------------------------------------------
module alu_exec_seq #(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_alu_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_eq,
`ifdef ALU_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_illegal
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1010;

    typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero, r_eq, r_illegal;
    logic [WIDTH-1:0]   r_acc, r_mcand, r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mul_eq;

    logic               w_accept, w_is_mul, w_mul_done;
    logic [WIDTH-1:0]   w_sum, w_diff, w_alu_res, w_acc_nxt;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_alu_ill;

    assign o_in_ready  = (r_state == ST_IDLE);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_is_mul    = (i_alu_ctrl == OP_MUL);
    assign w_mul_done  = (r_state == ST_MUL_BUSY) && (r_cnt == LAST_STEP);

    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_shamt = i_b[SHAMT_W-1:0];

    // One shift-add step: add the shifted multiplicand when the multiplier
    // LSB is set; the sum naturally truncates to WIDTH bits.
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Single-cycle ops.  MUL yields nothing here; the engine owns its result.
    always_comb begin
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        case (i_alu_ctrl)
            OP_AND: w_alu_res = i_a & i_b;
            OP_OR:  w_alu_res = i_a | i_b;
            OP_ADD: w_alu_res = w_sum;
            OP_SUB: w_alu_res = w_diff;
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_MUL: w_alu_res = '0;
            OP_XOR: w_alu_res = i_a ^ i_b;
            OP_SLL: w_alu_res = (int'(w_shamt) >= WIDTH) ? '0 : (i_a << w_shamt);
            default: w_alu_ill = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept && w_is_mul) w_state_nxt = ST_MUL_BUSY;
            ST_MUL_BUSY: if (w_mul_done)           w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: result registers and multiply engine
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_eq        <= 1'b0;
            r_illegal   <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_mul_eq    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == ST_MUL_BUSY) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_done) begin
                    r_result    <= w_acc_nxt;
                    r_zero      <= (w_acc_nxt == '0);
                    r_eq        <= r_mul_eq;
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                end
            end else if (w_accept) begin
                if (w_is_mul) begin
                    r_mcand  <= i_a;
                    r_mplier <= i_b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    // eq belongs to the accepted operands, so capture it now
                    r_mul_eq <= (i_a == i_b);
                end else begin
                    r_result    <= w_alu_res;
                    r_zero      <= (w_alu_res == '0);
                    r_eq        <= (i_a == i_b);
                    r_illegal   <= w_alu_ill;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_eq        = r_eq;
    assign o_illegal   = r_illegal;

`ifdef ALU_OVF_EN
    logic w_alu_ovf;
    logic r_ovf;

    // ADD: same-sign operands, result sign flips.
    // SUB: operands differ in sign, result sign differs from a.
    always_comb begin
        w_alu_ovf = 1'b0;
        case (i_alu_ctrl)
            OP_ADD: w_alu_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
            OP_SUB: w_alu_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            default: w_alu_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                   r_ovf <= 1'b0;
        else if (w_mul_done)            r_ovf <= 1'b0;
        else if (w_accept && !w_is_mul) r_ovf <= w_alu_ovf;
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   alu_ctrl = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero, eq, illegal;
    logic [W-1:0] result;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_alu_ctrl(alu_ctrl), .i_a(a), .i_b(b), .o_out_valid(out_valid),
        .o_result(result), .o_zero(zero), .o_eq(eq),
`ifdef ALU_OVF_EN
        .o_ovf(ovf),
`endif
        .o_illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return v[W-1] ? (longint'(v) - (longint'(1) << W)) : longint'(v);
    endfunction

    // Reference semantics from the code table, in plain integer arithmetic.
    function automatic void ref_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] r, output logic ill, output logic ov);
        longint s;
        longint lim;
        lim = longint'(1) << (W - 1);
        r = '0; ill = 1'b0; ov = 1'b0;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                r = W'(longint'(x) + longint'(y));
                s = sx(x) + sx(y);
                ov = (s >= lim) || (s < -lim);
            end
            4'b1010: begin
                r = W'(longint'(x) - longint'(y));
                s = sx(x) - sx(y);
                ov = (s >= lim) || (s < -lim);
            end
            4'b0011: r = (sx(x) < sx(y)) ? W'(1) : W'(0);
            4'b0100: r = W'(longint'(x) * longint'(y));
            4'b0101: r = x ^ y;
            4'b0110: r = (int'(y[4:0]) >= W) ? '0 : W'(longint'(x) << y[4:0]);
            default: ill = 1'b1;
        endcase
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic         m_init = 1'b0;
    logic         m_busy = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_pend_r = '0;
    logic         m_pend_eq = 1'b0;
    logic         e_ready = 1'b1, e_valid = 1'b0, e_zero = 1'b0, e_eq = 1'b0, e_ill = 1'b0, e_ovf = 1'b0;
    logic [W-1:0] e_res = '0;

    always @(negedge clk) begin
        logic         t_ill, t_ov;
        logic [W-1:0] t_r;
        if (m_init) begin
            chk("in_ready", in_ready, e_ready);
            chk("out_valid", out_valid, e_valid);
            if (e_valid) begin
                chk("result", result, e_res);
                chk("zero", zero, e_zero);
                chk("eq", eq, e_eq);
                chk("illegal", illegal, e_ill);
`ifdef ALU_OVF_EN
                chk("ovf", ovf, e_ovf);
`endif
            end
        end
        // predict outputs after the coming rising edge
        if (!rst_n) begin
            m_init = 1'b1; m_busy = 1'b0; m_left = 0;
            e_valid = 1'b0; e_res = '0; e_zero = 1'b0; e_eq = 1'b0; e_ill = 1'b0; e_ovf = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; e_valid = 1'b1; e_res = m_pend_r; e_zero = (m_pend_r == 0);
                    e_eq = m_pend_eq; e_ill = 1'b0; e_ovf = 1'b0;
                end
            end else if (in_valid) begin
                ref_op(alu_ctrl, a, b, t_r, t_ill, t_ov);
                if (alu_ctrl == 4'b0100) begin
                    m_busy = 1'b1; m_left = W; m_pend_r = t_r; m_pend_eq = (a == b);
                end else begin
                    e_valid = 1'b1; e_res = t_r; e_ill = t_ill; e_ovf = t_ov;
                    e_zero = (t_r == 0); e_eq = (a == b);
                end
            end
        end
        e_ready = !m_busy;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctrl = c; a = x; b = y;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    endtask

    // One op from idle; wait (bounded) for its result and check literals.
    task automatic op_lit(input string name, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_r, input logic exp_z, input logic exp_eq,
                          input logic exp_ill, input int exp_lat, input int exp_busy);
        int n;
        int busy;
        busy = 0;
        drive(c, x, y);
        idle();
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) busy++;
        end
        chk({name, " latency"}, n, exp_lat);
        chk({name, " busy cycles"}, busy, exp_busy);
        chk({name, " result"}, result, exp_r);
        chk({name, " zero"}, zero, exp_z);
        chk({name, " eq"}, eq, exp_eq);
        chk({name, " illegal"}, illegal, exp_ill);
    endtask

    initial begin
        int vcnt;
        // reset then idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset result", result, 24'h0);

        // back-to-back ADD, SUB, SLT
        drive(4'b0010, 24'h000005, 24'h000003);
        drive(4'b1010, 24'h000005, 24'h000003);
        @(negedge clk);
        chk("b2b add valid", out_valid, 1'b1);
        chk("b2b add result", result, 24'h000008);
        drive(4'b0011, 24'hFFFFFF, 24'h000001);
        @(negedge clk);
        chk("b2b sub valid", out_valid, 1'b1);
        chk("b2b sub result", result, 24'h000002);
        idle();
        @(negedge clk);
        chk("b2b slt valid", out_valid, 1'b1);
        chk("b2b slt result", result, 24'h000001);
        @(negedge clk);
        chk("b2b trailing valid", out_valid, 1'b0);

        // wrap and shift edges
        op_lit("add wrap", 4'b0010, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b0, 1, 0);
        op_lit("sll 23",   4'b0110, 24'h000001, 24'd23,     24'h800000, 1'b0, 1'b0, 1'b0, 1, 0);
        op_lit("sll 24",   4'b0110, 24'h000001, 24'd24,     24'h000000, 1'b1, 1'b0, 1'b0, 1, 0);
        op_lit("sub eq",   4'b1010, 24'h123456, 24'h123456, 24'h000000, 1'b1, 1'b1, 1'b0, 1, 0);

        // multiply
        op_lit("mul",      4'b0100, 24'h000123, 24'h000456, 24'h04EDC2, 1'b0, 1'b0, 1'b0, 25, 24);
        op_lit("mul trunc",4'b0100, 24'h001000, 24'h001000, 24'h000000, 1'b1, 1'b1, 1'b0, 25, 24);

        // illegal code
        op_lit("illegal",  4'b1111, 24'h00ABCD, 24'h001234, 24'h000000, 1'b1, 1'b0, 1'b1, 1, 0);

`ifdef ALU_OVF_EN
        op_lit("ovf add",  4'b0010, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b0, 1, 0);
        chk("ovf add flag", ovf, 1'b1);
        op_lit("ovf sub",  4'b1010, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b0, 1'b0, 1'b0, 1, 0);
        chk("ovf sub flag", ovf, 1'b1);
        op_lit("ovf none", 4'b0010, 24'h000001, 24'h000001, 24'h000002, 1'b0, 1'b1, 1'b0, 1, 0);
        chk("ovf none flag", ovf, 1'b0);
`endif

        // reset at step 10 of a MUL aborts it
        drive(4'b0100, 24'h000777, 24'h000333);
        idle();
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("abort no out_valid", vcnt, 0);
        chk("abort in_ready", in_ready, 1'b1);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            int mode;
            @(posedge clk); #1;
            rst_n    = ($urandom_range(0, 399) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            alu_ctrl = 4'($urandom_range(0, 15));
            mode     = $urandom_range(0, 3);
            case (mode)
                0: begin a = W'($urandom); b = W'($urandom); end
                1: begin a = W'($urandom_range(0, 31)); b = W'($urandom_range(0, 31)); end
                2: begin
                    a = ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
                    b = ($urandom_range(0, 1) != 0) ? 24'hFFFFFF : 24'h000001;
                end
                default: begin a = W'($urandom); b = a; end
            endcase
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- 24-bit execute-stage ALU that consumes the 4-bit ALUCtrl code from the ALU control decoder, plus operands A/B from the register file and immediate mux.
- Logic, add/sub, compare and shift ops complete with 1-cycle registered latency.
- MUL runs on an iterative 24-step shift-add engine behind a valid/ready handshake, so the datapath stalls while it is busy.

Parameters:
- WIDTH, 24, operand/result width in bits.
- SHAMT_W, 5, number of low B bits used as the SLL shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- alu_ctrl  input  4  operation code from the ALU control decoder.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse; result/zero/eq/illegal valid.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- eq  output  1  a == b of the accepted request; used for BNE.
- illegal  output  1  accepted alu_ctrl not in the code table.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, eq=0, illegal=0, mul counter=0.
  - Reset mid-MUL aborts the multiply with no out_valid.
- Code table:
  - 0000 AND, 0001 OR, 0010 ADD, 1010 SUB.
  - 0011 SLT: signed; result = 1 if $signed(a) < $signed(b), else 0.
  - 0100 MUL: low 24 bits of the unsigned product.
  - 0101 XOR.
  - 0110 SLL: a << b[SHAMT_W-1:0]; shift amounts >= 24 give 0.
- All other codes:
  - result=0, illegal=1, still 1-cycle latency.
- Arithmetic:
  - ADD/SUB wrap modulo 2^24.
  - eq is computed for every op and is independent of alu_ctrl; BNE branches on !eq.
- Handshake:
  - Request accepted when in_valid && in_ready.
  - Inputs are sampled only at acceptance; later changes are ignored.
- States: IDLE, MUL_BUSY.
- IDLE:
  - in_ready=1.
  - Accepted non-MUL op: at the next posedge, result/zero/eq/illegal are registered and out_valid=1 for exactly one cycle. Stay in IDLE; back-to-back accepts give one result per cycle.
  - Accepted MUL: latch multiplicand=a and multiplier=b, clear the accumulator, counter=0, go to MUL_BUSY. in_ready=0 from the next cycle; out_valid=0 that cycle.
- MUL_BUSY:
  - Each cycle: if the multiplier LSB is 1, acc += multiplicand (truncate to WIDTH). Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After the 24th step (counter==23), return to IDLE. At that edge: result=acc, zero, eq, out_valid=1.
  - Total latency accept→out_valid = 25 cycles.
  - in_valid is ignored while busy; the upstream stage must hold.
- Simultaneous events:
  - out_valid of the previous op and acceptance of a new op in the same cycle are legal.
  - rst_n=0 overrides everything.
- out_valid is never asserted without a prior accepted request.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), registered with result; reset 0.
  - ovf=1 on signed overflow of ADD (operands same sign, result sign differs) or SUB (operands differ in sign, result sign differs from a).
  - ovf=0 for all other ops, including MUL.
- Undefined:
  - No ovf port.
  - Behaviour otherwise identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, result=0.
- Back-to-back ops: ADD a=0x000005 b=0x000003, next cycle SUB same operands, next cycle SLT a=0xFFFFFF b=0x000001 -> three consecutive out_valid pulses; results 0x000008, 0x000002, 0x000001.
- Wrap and shift edges:
  - ADD 0xFFFFFF+0x000001 -> result 0, zero=1.
  - SLL a=0x000001 b=23 -> 0x800000.
  - SLL b=24 -> 0.
  - SUB a=b=0x123456 -> zero=1, eq=1.
- Multiply:
  - MUL a=0x000123 b=0x000456 -> in_ready low for 24 cycles, out_valid 25 cycles after accept, result 0x04EDC2.
  - MUL 0x001000*0x001000 -> 0 (truncated), zero=1.
- Abort and illegal:
  - rst_n=0 at step 10 of a MUL -> no out_valid, in_ready=1 after reset.
  - alu_ctrl=1111 -> illegal=1, result=0.
- ALU_OVF_EN:
  - ADD 0x7FFFFF+0x000001 -> ovf=1.
  - SUB 0x800000-0x000001 -> ovf=1.
  - ADD 1+1 -> ovf=0.
